// File: rtl/rf_wport_sched.sv
// +-----------------------------------------------------------------------------+
// | rf_wport_sched: shares the RF write port between writeback and mul/div HI/LO |
// | Rev 1.0                                                                      |
// +-----------------------------------------------------------------------------+
`default_nettype none

module rf_wport_sched #(
  parameter logic [5:0]  HI_ADDR  = 6'd32,
  parameter logic [5:0]  LO_ADDR  = 6'd33,
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        wb_reg_en,
  input  logic [5:0]  wb_reg_waddr,
  input  logic [31:0] wb_reg_wdata,
  input  logic        md_valid,
  input  logic [31:0] md_hi,
  input  logic [31:0] md_lo,
  output logic        md_ready,
  output logic        md_busy,
  output logic        pipe_stall,
  output logic        rf_we,
  output logic [5:0]  rf_waddr,
  output logic [31:0] rf_wdata
);

  localparam logic [3:0] c_MAX_WAIT = 4'(MAX_WAIT);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WR_HI = 2'd1,
    S_WR_LO = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] hi_buf_q, hi_buf_d;
  logic [31:0] lo_buf_q, lo_buf_d;
  logic [3:0]  wait_cnt_q, wait_cnt_d;

  logic w_hazard;
  logic w_drain_own;

  assign w_hazard = wb_reg_en && ((wb_reg_waddr == HI_ADDR) || (wb_reg_waddr == LO_ADDR));

  // A drain write is suppressed while reset is asserted so a result being
  // discarded never reaches the register file.
  assign w_drain_own = resetn && (state_q != S_IDLE) &&
                       (!wb_reg_en || w_hazard || (wait_cnt_q == c_MAX_WAIT));

  assign md_ready = (state_q == S_IDLE);
  assign md_busy  = (state_q != S_IDLE);

  always_comb begin
    state_d    = state_q;
    hi_buf_d   = hi_buf_q;
    lo_buf_d   = lo_buf_q;
    wait_cnt_d = wait_cnt_q;
    rf_we      = wb_reg_en;
    rf_waddr   = wb_reg_waddr;
    rf_wdata   = wb_reg_wdata;
    pipe_stall = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (md_valid) begin
          hi_buf_d   = md_hi;
          lo_buf_d   = md_lo;
          wait_cnt_d = 4'd0;
          state_d    = S_WR_HI;
        end
      end
      S_WR_HI, S_WR_LO: begin
        if (w_drain_own) begin
          rf_we      = 1'b1;
          pipe_stall = wb_reg_en;
          wait_cnt_d = 4'd0;
          if (state_q == S_WR_HI) begin
            rf_waddr = HI_ADDR;
            rf_wdata = hi_buf_q;
            state_d  = S_WR_LO;
          end else begin
            rf_waddr = LO_ADDR;
            rf_wdata = lo_buf_q;
            state_d  = S_IDLE;
          end
        end else if (wait_cnt_q != c_MAX_WAIT) begin
          wait_cnt_d = wait_cnt_q + 4'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q    <= S_IDLE;
      hi_buf_q   <= 32'd0;
      lo_buf_q   <= 32'd0;
      wait_cnt_q <= 4'd0;
    end else begin
      state_q    <= state_d;
      hi_buf_q   <= hi_buf_d;
      lo_buf_q   <= lo_buf_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_rf_wport_sched.sv
// +-----------------------------------------------------------------------------+
// | tb_rf_wport_sched: directed vectors for the RF write-port scheduler         |
// | Rev 1.0                                                                      |
// +-----------------------------------------------------------------------------+
`default_nettype none

module tb_rf_wport_sched;

  logic        clk = 1'b0;
  logic        resetn;
  logic        wb_reg_en;
  logic [5:0]  wb_reg_waddr;
  logic [31:0] wb_reg_wdata;
  logic        md_valid;
  logic [31:0] md_hi;
  logic [31:0] md_lo;
  logic        md_ready;
  logic        md_busy;
  logic        pipe_stall;
  logic        rf_we;
  logic [5:0]  rf_waddr;
  logic [31:0] rf_wdata;

  int n_vec = 0;
  int n_err = 0;

  rf_wport_sched dut (
    .clk          (clk),
    .resetn       (resetn),
    .wb_reg_en    (wb_reg_en),
    .wb_reg_waddr (wb_reg_waddr),
    .wb_reg_wdata (wb_reg_wdata),
    .md_valid     (md_valid),
    .md_hi        (md_hi),
    .md_lo        (md_lo),
    .md_ready     (md_ready),
    .md_busy      (md_busy),
    .pipe_stall   (pipe_stall),
    .rf_we        (rf_we),
    .rf_waddr     (rf_waddr),
    .rf_wdata     (rf_wdata)
  );

  always #5 clk = ~clk;

  // Packed view: {stall, ready, busy, we, waddr[5:0], wdata[31:0]}
  function automatic logic [63:0] pk(input logic st, input logic rdy, input logic bsy,
                                     input logic we, input logic [5:0] a, input logic [31:0] d);
    return {22'd0, st, rdy, bsy, we, a, d};
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (stall,ready,busy,we,addr,data)", tag, got, exp);
    end
  endtask

  // Check all outputs a settle delay after the inputs were driven.
  task automatic expect_out(input string tag, input logic st, input logic rdy, input logic bsy,
                            input logic we, input logic [5:0] a, input logic [31:0] d);
    #1;
    chk(tag, pk(pipe_stall, md_ready, md_busy, rf_we, rf_waddr, rf_wdata),
        pk(st, rdy, bsy, we, a, d));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wb(input logic en, input logic [5:0] a, input logic [31:0] d);
    wb_reg_en    = en;
    wb_reg_waddr = a;
    wb_reg_wdata = d;
  endtask

  task automatic md(input logic v, input logic [31:0] hi, input logic [31:0] lo);
    md_valid = v;
    md_hi    = hi;
    md_lo    = lo;
  endtask

  initial begin
    resetn = 1'b0;
    wb(1'b0, 6'd0, 32'd0);
    md(1'b0, 32'd0, 32'd0);
    tick();
    tick();

    // Reset release: idle pass-through
    resetn = 1'b1;
    wb(1'b1, 6'd5, 32'h0000_1234);
    expect_out("reset_pass", 0, 1, 0, 1, 6'd5, 32'h0000_1234);

    // Idle drain; md_valid while busy must be ignored
    wb(1'b0, 6'd0, 32'd0);
    md(1'b1, 32'hAAAA_0000, 32'h0000_BBBB);
    expect_out("drain_accept", 0, 1, 0, 0, 6'd0, 32'd0);
    tick();
    md(1'b1, 32'hDEAD_DEAD, 32'hBEEF_BEEF);
    expect_out("drain_hi", 0, 0, 1, 1, 6'd32, 32'hAAAA_0000);
    tick();
    expect_out("drain_lo", 0, 0, 1, 1, 6'd33, 32'h0000_BBBB);
    md(1'b0, 32'd0, 32'd0);
    tick();
    expect_out("drain_done", 0, 1, 0, 0, 6'd0, 32'd0);

    // Starvation with pipeline writes to reg 7 every cycle
    md(1'b1, 32'h1111_1111, 32'h2222_2222);
    tick();
    md(1'b0, 32'd0, 32'd0);
    wb(1'b1, 6'd7, 32'h0000_00C0);
    for (int i = 0; i < 4; i++) begin
      expect_out($sformatf("starve_hi_pass%0d", i), 0, 0, 1, 1, 6'd7, 32'h0000_00C0);
      tick();
    end
    expect_out("starve_hi_force", 1, 0, 1, 1, 6'd32, 32'h1111_1111);
    tick();
    for (int i = 0; i < 4; i++) begin
      expect_out($sformatf("starve_lo_pass%0d", i), 0, 0, 1, 1, 6'd7, 32'h0000_00C0);
      tick();
    end
    expect_out("starve_lo_force", 1, 0, 1, 1, 6'd33, 32'h2222_2222);
    tick();
    expect_out("starve_done", 0, 1, 0, 1, 6'd7, 32'h0000_00C0);

    // Hazard: pipeline write to LO while the result is buffered
    wb(1'b0, 6'd0, 32'd0);
    md(1'b1, 32'h3333_3333, 32'h4444_4444);
    tick();
    md(1'b0, 32'd0, 32'd0);
    wb(1'b1, 6'd33, 32'h5555_5555);
    expect_out("hazard_hi", 1, 0, 1, 1, 6'd32, 32'h3333_3333);
    tick();
    expect_out("hazard_lo", 1, 0, 1, 1, 6'd33, 32'h4444_4444);
    tick();
    expect_out("hazard_wb", 0, 1, 0, 1, 6'd33, 32'h5555_5555);

    // Simultaneous accept and writeback, then reset in WR_LO
    md(1'b1, 32'h6666_6666, 32'h7777_7777);
    wb(1'b1, 6'd9, 32'h0000_0099);
    expect_out("simul_wb", 0, 1, 0, 1, 6'd9, 32'h0000_0099);
    tick();
    md(1'b0, 32'd0, 32'd0);
    wb(1'b0, 6'd0, 32'd0);
    expect_out("simul_hi", 0, 0, 1, 1, 6'd32, 32'h6666_6666);
    tick();
    resetn = 1'b0;
    expect_out("rst_mid_nowrite", 0, 0, 1, 0, 6'd0, 32'd0);
    tick();
    resetn = 1'b1;
    expect_out("rst_mid_idle", 0, 1, 0, 0, 6'd0, 32'd0);
    tick();
    expect_out("rst_mid_after", 0, 1, 0, 0, 6'd0, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
